// File: rtl/spr_dma_pkg.sv
// Sprite DMA shared constants, state encoding and bus bundle.
// Imported by the interface-facing top module.
package spr_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic [15:0] a;
    logic        r_nw;
    logic [7:0]  d;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{
    rdy:  1'b1,
    en:   1'b0,
    a:    16'h0000,
    r_nw: 1'b1,
    d:    8'h00
  };

  localparam bus_out_t BUS_STALL = '{
    rdy:  1'b0,
    en:   1'b0,
    a:    16'h0000,
    r_nw: 1'b1,
    d:    8'h00
  };

endpackage

// File: rtl/spr_dma_if.sv
// CPU-side and DMA-side bus signals of the sprite DMA.
// slave = the DMA block, master = CPU core / bus decoder side.
interface spr_dma_if;
  logic        cpu_cyc_en_in;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic [7:0]  bus_d_in;
  logic        cpu_rdy_out;
  logic        dma_en_out;
  logic [15:0] dma_a_out;
  logic        dma_r_nw_out;
  logic [7:0]  dma_d_out;

  modport slave (
    input  cpu_cyc_en_in,
    input  cpu_a_in,
    input  cpu_r_nw_in,
    input  cpu_d_in,
    input  bus_d_in,
    output cpu_rdy_out,
    output dma_en_out,
    output dma_a_out,
    output dma_r_nw_out,
    output dma_d_out
  );

  modport master (
    output cpu_cyc_en_in,
    output cpu_a_in,
    output cpu_r_nw_in,
    output cpu_d_in,
    output bus_d_in,
    input  cpu_rdy_out,
    input  dma_en_out,
    input  dma_a_out,
    input  dma_r_nw_out,
    input  dma_d_out
  );
endinterface

// File: rtl/spr_dma.sv
// Sprite DMA (0x4014): stalls the CPU and copies one page
// into the PPU OAM data port, one bus access per CPU cycle.
module spr_dma
  import spr_dma_pkg::*;
(
  input logic     clk_in,
  input logic     rst_n_in,
  spr_dma_if.slave bus
);

  state_t   q_state, d_state;
  logic     q_parity, d_parity;
  logic [7:0] q_idx, d_idx;
  logic [7:0] q_page, d_page;
  logic [7:0] q_buf, d_buf;
  bus_out_t q_out, d_out;

  logic trig;
  assign trig = (bus.cpu_a_in == DMA_REG_ADDR) &&
                !bus.cpu_r_nw_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      q_state  <= S_IDLE;
      q_parity <= 1'b0;
      q_idx    <= 8'h00;
      q_page   <= 8'h00;
      q_buf    <= 8'h00;
      q_out    <= BUS_IDLE;
    end else begin
      q_state  <= d_state;
      q_parity <= d_parity;
      q_idx    <= d_idx;
      q_page   <= d_page;
      q_buf    <= d_buf;
      q_out    <= d_out;
    end
  end

  always_comb begin
    d_state  = q_state;
    d_parity = q_parity;
    d_idx    = q_idx;
    d_page   = q_page;
    d_buf    = q_buf;
    d_out    = q_out;
    if (bus.cpu_cyc_en_in) begin
      d_parity = ~q_parity;
      unique case (q_state)
        S_IDLE: begin
          if (trig) begin
            d_page  = bus.cpu_d_in;
            d_idx   = 8'h00;
            d_state = S_HALT;
          end
        end
        S_HALT: begin
          d_state = q_parity ? S_ALIGN : S_READ;
        end
        S_ALIGN: begin
          d_state = S_READ;
        end
        S_READ: begin
          d_buf   = bus.bus_d_in;
          d_state = S_WRITE;
        end
        S_WRITE: begin
          d_idx   = q_idx + 8'h01;
          d_state = (q_idx == 8'hFF) ? S_IDLE : S_READ;
        end
        default: begin
          d_state = S_IDLE;
        end
      endcase
      // Outputs are registered from the next state, so they
      // describe the access of the CPU cycle just starting.
      unique case (d_state)
        S_IDLE:  d_out = BUS_IDLE;
        S_HALT:  d_out = BUS_STALL;
        S_ALIGN: d_out = BUS_STALL;
        S_READ: begin
          d_out      = BUS_STALL;
          d_out.en   = 1'b1;
          d_out.a    = {d_page, d_idx};
        end
        S_WRITE: begin
          d_out      = BUS_STALL;
          d_out.en   = 1'b1;
          d_out.a    = OAM_DATA_ADDR;
          d_out.r_nw = 1'b0;
          d_out.d    = d_buf;
        end
        default: d_out = BUS_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdy_out  = q_out.rdy;
  assign bus.dma_en_out   = q_out.en;
  assign bus.dma_a_out    = q_out.a;
  assign bus.dma_r_nw_out = q_out.r_nw;
  assign bus.dma_d_out    = q_out.d;

endmodule

// File: tb/tb_spr_dma.sv
// Scoreboard bench for spr_dma: stimulus queues expected
// reads/writes, a monitor checks each CPU-cycle bus access.
module tb_spr_dma;

  logic clk;
  logic rst_n;
  int   div;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   rd_cnt;
  logic [15:0] last_rd;
  logic [15:0] rq[$];
  logic [7:0]  wq[$];

  spr_dma_if bus();

  spr_dma dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a[7:0] ^ {a[3:0], a[7:4]}) + a[15:8] + 8'h11;
  endfunction

  assign bus.bus_d_in = mem(bus.dma_a_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.cpu_a_in    = 16'h0000;
    bus.cpu_r_nw_in = 1'b1;
    bus.cpu_d_in    = 8'h00;
  endtask

  task automatic cyc();
    for (int k = 0; k < div; k++) begin
      bus.cpu_cyc_en_in = (k == div - 1);
      @(posedge clk);
      #1;
    end
    bus.cpu_cyc_en_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_cyc_en_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rq.delete();
    wq.delete();
  endtask

  // pre: idle CPU cycles that set the parity seen in HALT
  task automatic do_dma(input logic [7:0] pg,
                        input int pre,
                        input int exp_lat,
                        input int ign_at,
                        input int abort_at);
    int  n;
    int  w0;
    logic [15:0] ra;
    bit  aborted;
    repeat (pre) cyc();
    for (int i = 0; i < 256; i++) begin
      ra = {pg, 8'(i)};
      rq.push_back(ra);
      wq.push_back(mem(ra));
    end
    w0 = wr_cnt;
    bus.cpu_a_in    = 16'h4014;
    bus.cpu_r_nw_in = 1'b0;
    bus.cpu_d_in    = pg;
    cyc();
    set_idle();
    n = 0;
    aborted = 1'b0;
    while (bus.cpu_rdy_out == 1'b0 && n < 600 && !aborted) begin
      if (n == ign_at) begin
        bus.cpu_a_in    = 16'h4014;
        bus.cpu_r_nw_in = 1'b0;
        bus.cpu_d_in    = 8'h05;
      end
      cyc();
      set_idle();
      n++;
      if (abort_at > 0 && wr_cnt - w0 == abort_at) begin
        do_reset();
        aborted = 1'b1;
      end
    end
    if (aborted) begin
      chk("abort_rdy", 32'(bus.cpu_rdy_out), 32'd1);
      chk("abort_en", 32'(bus.dma_en_out), 32'd0);
      repeat (20) cyc();
      chk("abort_wr", wr_cnt - w0, abort_at);
    end else begin
      chk("latency", n, exp_lat);
      chk("wr_count", wr_cnt - w0, 256);
      chk("rq_left", rq.size(), 0);
      chk("wq_left", wq.size(), 0);
      repeat (4) cyc();
    end
  endtask

  // Monitor: one access per CPU cycle, checked on the
  // negedge of the clock carrying the cycle-enable pulse.
  initial begin
    logic [26:0] prev_o;
    logic [26:0] cur_o;
    bit prev_en;
    bit have_prev;
    have_prev = 1'b0;
    prev_en   = 1'b0;
    prev_o    = '0;
    forever begin
      @(negedge clk);
      cur_o = {bus.cpu_rdy_out, bus.dma_en_out, bus.dma_a_out,
               bus.dma_r_nw_out, bus.dma_d_out};
      if (rst_n && have_prev && !prev_en)
        chk("hold", cur_o, prev_o);
      prev_o    = cur_o;
      prev_en   = bus.cpu_cyc_en_in;
      have_prev = rst_n;
      if (rst_n && bus.cpu_cyc_en_in) begin
        if (bus.dma_en_out && !bus.dma_r_nw_out) begin
          chk("wr_addr", bus.dma_a_out, 16'h2004);
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_extra actual=%h required=none",
                     bus.dma_d_out);
          end else begin
            chk("wr_data", bus.dma_d_out, wq.pop_front());
          end
          wr_cnt++;
        end else if (bus.dma_en_out) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_extra actual=%h required=none",
                     bus.dma_a_out);
          end else begin
            chk("rd_addr", bus.dma_a_out, rq.pop_front());
          end
          last_rd = bus.dma_a_out;
          rd_cnt++;
        end else begin
          chk("idle_bus",
              {bus.dma_a_out, bus.dma_r_nw_out, bus.dma_d_out},
              {16'h0000, 1'b1, 8'h00});
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    wr_cnt  = 0;
    rd_cnt  = 0;
    last_rd = 16'h0000;
    div     = 1;
    rst_n   = 1'b0;
    bus.cpu_cyc_en_in = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rdy", 32'(bus.cpu_rdy_out), 32'd1);
    chk("rst_en", 32'(bus.dma_en_out), 32'd0);
    chk("rst_a", 32'(bus.dma_a_out), 32'h0);
    chk("rst_rnw", 32'(bus.dma_r_nw_out), 32'd1);
    chk("rst_d", 32'(bus.dma_d_out), 32'h0);

    do_dma(8'h02, 1, 513, -1, 0);
    do_dma(8'h02, 1, 514, -1, 0);
    do_dma(8'hFF, 0, 513, -1, 0);
    chk("last_rd_ff", last_rd, 16'hFFFF);
    do_dma(8'h02, 0, 513, 1, 0);
    chk("last_rd_ign", last_rd, 16'h02FF);
    do_dma(8'h02, 0, 0, -1, 100);
    div = 3;
    do_dma(8'h37, 1, 513, -1, 0);
    chk("last_rd_div3", last_rd, 16'h37FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
